// File: rtl/fsk_byte_receiver.sv
// FSK byte receiver: slices period-count samples into mark/space bits and
// recovers start/LSB-first data/stop framed bytes, timing in valid samples.
//
// Ports:
//   clk_200M         sole clock
//   reset_200M       synchronous active-high reset
//   sample_i         16-bit period-count sample
//   sample_valid_i   strobe, sample_i holds a new sample this cycle
//   compare_point_i  slicing threshold (mark when sample < threshold)
//   bit_o            most recent sliced bit
//   data_o           last correctly framed byte
//   data_valid_o     one-cycle pulse when data_o updates
//   framing_error_o  one-cycle pulse on a bad stop bit
//   busy_o           high whenever the receiver is not idle
module fsk_byte_receiver #(
    parameter int SAMPLES_PER_BIT = 8,
    parameter int DATA_BITS       = 8
) (
    input  logic                 clk_200M,
    input  logic                 reset_200M,
    input  logic [15:0]          sample_i,
    input  logic                 sample_valid_i,
    input  logic [15:0]          compare_point_i,
    output logic                 bit_o,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 data_valid_o,
    output logic                 framing_error_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(SAMPLES_PER_BIT + 1);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF = CW'(SAMPLES_PER_BIT / 2);
    localparam logic [CW-1:0] FULL = CW'(SAMPLES_PER_BIT);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_n;
    logic [CW-1:0]        idx;
    logic [BW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_cnt_n;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_n;
    logic [DATA_BITS-1:0] shifted;
    logic [DATA_BITS-1:0] data_n;
    logic                 bit_n;
    logic                 valid_n;
    logic                 err_n;
    logic                 s;

    always_ff @(posedge clk_200M) begin
        if (reset_200M) begin
            state           <= IDLE;
            cnt             <= '0;
            bit_cnt         <= '0;
            shift           <= '0;
            bit_o           <= 1'b1;
            data_o          <= '0;
            data_valid_o    <= 1'b0;
            framing_error_o <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            bit_cnt         <= bit_cnt_n;
            shift           <= shift_n;
            bit_o           <= bit_n;
            data_o          <= data_n;
            data_valid_o    <= valid_n;
            framing_error_o <= err_n;
        end
    end

    assign busy_o = (state != IDLE);

    always_comb begin
        s         = (sample_i < compare_point_i);
        idx       = cnt + CW'(1);
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        bit_n     = bit_o;
        data_n    = data_o;
        valid_n   = 1'b0;
        err_n     = 1'b0;

        // Data arrives LSB first, so each new bit enters at the MSB.
        shifted              = shift >> 1;
        shifted[DATA_BITS-1] = s;

        if (sample_valid_i) begin
            bit_n = s;
            case (state)
                IDLE: begin
                    if (!s) begin
                        state_n = START;
                        cnt_n   = '0;
                    end
                end
                START: begin
                    if (idx == HALF) begin
                        cnt_n = '0;
                        if (!s) begin
                            state_n   = DATA;
                            bit_cnt_n = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = idx;
                    end
                end
                // From here on cnt counts from the mid-point of the
                // previous bit, so a full bit period lands on mid-bit.
                DATA: begin
                    if (idx == FULL) begin
                        cnt_n   = '0;
                        shift_n = shifted;
                        if (bit_cnt == LAST) begin
                            state_n = STOP;
                        end else begin
                            bit_cnt_n = bit_cnt + BW'(1);
                        end
                    end else begin
                        cnt_n = idx;
                    end
                end
                STOP: begin
                    if (idx == FULL) begin
                        cnt_n = '0;
                        if (s) begin
                            data_n  = shift;
                            valid_n = 1'b1;
                            state_n = IDLE;
                        end else begin
                            err_n   = 1'b1;
                            state_n = BREAK;
                        end
                    end else begin
                        cnt_n = idx;
                    end
                end
                // Hold off until the line returns to mark so a stuck-low
                // line cannot retrigger a start.
                BREAK: begin
                    if (s) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule
